pc_fetch_ctrl: RTL
==================

Name: pc_fetch_ctrl

Overview:
- Sequences the program counter and the instruction-fetch handshake for the MIPS pipeline.
- Selects the next PC from three sources, in fixed priority: exception vector, ERET return (EPC), and branch/jump target from the NPC adder.
- Runs the request/ready handshake with instruction memory.
- Holds the fetched instruction in a one-entry buffer consumed by decode under the hazard-unit stall.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_4180, exception entry address.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard unit: decode does not accept the buffered instruction this cycle.
- br_req  input  1  branch/jump redirect request.
- br_target  input  32  redirect target from the NPC adder.
- eret_req  input  1  ERET redirect request.
- epc  input  32  ERET target.
- exc_req  input  1  exception redirect request.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; equals pc.
- imem_ready  input  1  memory has returned data this cycle.
- imem_rdata  input  32  fetched instruction.
- pc  output  32  current fetch PC.
- if_valid  output  1  instruction buffer holds a valid instruction.
- if_instr  output  32  buffered instruction.
- if_pc  output  32  PC of the buffered instruction.
- if_pc4  output  32  if_pc + 4, fed to the NPC adder.
- addr_err  output  1  pc misaligned (pc[1:0] != 0).

Behaviour:
- Reset state:
  - pc = RESET_PC, state = BOOT.
  - if_valid = 0, if_instr = 0, if_pc = RESET_PC.
  - pend_target = 0, pend_exc = 0, busy = 0, imem_req = 0.
- States: BOOT, FETCH, FLUSH.
- Redirect event `redir` = exc_req | eret_req | br_req.
  - Target priority: exc_req → EXC_VECTOR; else eret_req → epc; else br_target.
  - Simultaneous requests resolve by this priority only.
- Outstanding transaction `busy`:
  - Set when imem_req & !imem_ready; cleared on imem_ready.
  - While busy, imem_req stays 1 and imem_addr stays stable regardless of stall.
- imem_req:
  - (state==FETCH & !addr_err & (!if_valid | !stall)) | state==FLUSH | busy.
  - Combinational from the state registers and stall.
- Buffer consume: if_valid & !stall.
- BOOT:
  - imem_req = 0; next cycle → FETCH.
  - Redirects in BOOT are ignored.
- FETCH, no redirect:
  - imem_req & imem_ready: if_instr <= imem_rdata, if_pc <= pc, if_valid <= 1, pc <= pc + 4, all on the same edge.
  - Consume without a load: if_valid <= 0.
  - Load and consume in the same cycle: buffer replaced, if_valid stays 1.
  - Fetch latency: pc presented with imem_req → instruction visible on if_instr the cycle after imem_ready.
- Redirect in FETCH:
  - if_valid <= 0 (flush) on that edge.
  - If no transaction is in flight (imem_req = 0, or imem_ready = 1 this cycle): pc <= target, any returned data discarded, stay FETCH.
  - Otherwise: pend_target <= target, pend_exc <= exc_req, → FLUSH.
- FLUSH:
  - imem_req = 1, pc unchanged, if_valid held at 0.
  - On imem_ready: data discarded, pc <= pend_target, → FETCH.
  - A new redirect in FLUSH overwrites pend_target, except a non-exception redirect never overwrites while pend_exc = 1.
  - If redirect and imem_ready coincide in FLUSH: the new target wins under the same rule, → FETCH.
- stall has no effect on pc or state except through imem_req gating and buffer consumption.
- addr_err:
  - Asserted combinationally while pc[1:0] != 0.
  - Suppresses new requests in FETCH (in-flight ones complete).
  - Cleared only by a redirect (normally exception).
- pc + 4 wraps modulo 2^32 (32'hFFFF_FFFC → 0).
- reset asserted in any state, including FLUSH or busy: returns to reset values next edge; outstanding memory data is discarded.
- if_pc4 = if_pc + 4, combinational.

Test Plan:
- Reset, then imem_ready held 1, no stall → imem_req 0 in BOOT; if_pc sequence 0x3000, 0x3004, 0x3008 on consecutive cycles, if_valid 1 from cycle 3.
- if_valid = 1, stall = 1 for 3 cycles, ready = 1 → imem_req 0, if_instr and if_pc frozen, pc frozen. Release stall → next fetch loads and pc advances by 4.
- br_req with br_target 0x3100 while imem_ready = 0 (busy) → FLUSH; two cycles later ready → data discarded, pc = 0x3100, if_valid = 0, next fetch if_pc = 0x3100.
- exc_req and br_req in the same cycle → pc = 0x4180. Then br_req during FLUSH behind a pending exception → target stays 0x4180.
- eret_req with epc = 0x3204 → pc = 0x3204. br_target 0x3102 → addr_err = 1, imem_req = 0 until exc_req moves pc to 0x4180.
- reset asserted mid-FLUSH with imem_ready = 0 → next cycle pc = 0x3000, state BOOT, if_valid = 0, busy = 0.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// PC sequencer and instruction-fetch controller.
// Picks the next PC (exception > ERET > branch), runs the imem request/ready
// handshake and holds one fetched instruction for decode.
//
// Handshake: imem_req is a request, imem_ready marks the cycle the memory
// returns data for the request it accepted. Once imem_req is raised without
// imem_ready, the transaction is "busy". imem_req then stays high and
// imem_addr stays stable until imem_ready arrives, whatever stall does.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        br_req,
   input  logic [31:0] br_target,
   input  logic        eret_req,
   input  logic [31:0] epc,
   input  logic        exc_req,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc4,
   output logic        addr_err
);

   typedef enum logic [1:0] {BOOT, FETCH, FLUSH} state_t;

   state_t      state, state_nx;
   logic [31:0] pc_nx, if_instr_nx, if_pc_nx, pend_target, pend_target_nx;
   logic        if_valid_nx, pend_exc, pend_exc_nx, busy, busy_nx;
   logic        redir, keep_pend;
   logic [31:0] target;

   // Next-state, request and redirect logic; every register holds by default.
   always_comb begin
      addr_err       = (pc[1:0] != 2'b00);
      imem_req       = ((state == FETCH) && !addr_err && (!if_valid || !stall))
                       || (state == FLUSH) || busy;
      redir          = exc_req || eret_req || br_req;
      target         = exc_req ? EXC_VECTOR : (eret_req ? epc : br_target);
      keep_pend      = 1'b0;
      state_nx       = state;
      pc_nx          = pc;
      if_valid_nx    = if_valid;
      if_instr_nx    = if_instr;
      if_pc_nx       = if_pc;
      pend_target_nx = pend_target;
      pend_exc_nx    = pend_exc;
      busy_nx        = imem_ready ? 1'b0 : (imem_req ? 1'b1 : busy);
      case (state)
         BOOT: begin
            state_nx = FETCH;
         end
         FETCH: begin
            if (redir) begin
               if_valid_nx = 1'b0;
               if (!imem_req || imem_ready) begin
                  pc_nx = target;
               end else begin
                  pend_target_nx = target;
                  pend_exc_nx    = exc_req;
                  state_nx       = FLUSH;
               end
            end else if (imem_req && imem_ready) begin
               if_instr_nx = imem_rdata;
               if_pc_nx    = pc;
               if_valid_nx = 1'b1;
               pc_nx       = pc + 32'd4;
            end else if (if_valid && !stall) begin
               if_valid_nx = 1'b0;
            end
         end
         FLUSH: begin
            if_valid_nx = 1'b0;
            // A pending exception target is never displaced by a plain redirect.
            keep_pend   = pend_exc && !exc_req;
            if (redir && !keep_pend) begin
               pend_target_nx = target;
               pend_exc_nx    = exc_req;
            end
            if (imem_ready) begin
               pc_nx    = pend_target_nx;
               state_nx = FETCH;
            end
         end
         default: begin
            state_nx = BOOT;
         end
      endcase
   end

   // State register with synchronous reset; reset drops any in-flight data.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= BOOT;
         pc          <= RESET_PC;
         if_valid    <= 1'b0;
         if_instr    <= 32'h0;
         if_pc       <= RESET_PC;
         pend_target <= 32'h0;
         pend_exc    <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nx;
         pc          <= pc_nx;
         if_valid    <= if_valid_nx;
         if_instr    <= if_instr_nx;
         if_pc       <= if_pc_nx;
         pend_target <= pend_target_nx;
         pend_exc    <= pend_exc_nx;
         busy        <= busy_nx;
      end
   end

   assign imem_addr = pc;
   assign if_pc4    = if_pc + 32'd4;

endmodule
